tt_move_ctrl: RTL and testbench

Player-input front end for the tic-tac-toe board. Debounces six push-buttons, keeps a 3x3 cursor and checks the target cell is free, then issues a single-cycle place strobe with 1-based row/col to the board. It also watches the board's 2-bit game result to lock out moves after a win or draw, and pulses the board's active-high clear on a new-game request.

---
 rtl/tt_pkg.sv | 42 ++++
 rtl/tt_btn_debounce.sv | 48 ++++
 rtl/tt_move_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tt_move_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the tic-tac-toe move controller: game result codes,
// controller states, board geometry and cursor helpers.
package tt_pkg;

    localparam logic [1:0] GS_PLAY = 2'b00;
    localparam logic [1:0] GS_WIN1 = 2'b01;
    localparam logic [1:0] GS_WIN0 = 2'b10;
    localparam logic [1:0] GS_DRAW = 2'b11;

    localparam int BOARD_N = 9;

    localparam logic [1:0] CURSOR_ROW_RST = 2'd2;
    localparam logic [1:0] CURSOR_COL_RST = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLACE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_OVER   = 3'd3,
        ST_CLEAR  = 3'd4
    } move_state_e;

    // One cursor axis step over 1..3 with wrap; opposing requests cancel.
    function automatic logic [1:0] cursor_step(input logic [1:0] pos,
                                               input logic       dec,
                                               input logic       inc);
        logic [1:0] nxt;
        if (dec && !inc) begin
            nxt = (pos == 2'd1) ? 2'd3 : pos - 2'd1;
        end else if (inc && !dec) begin
            nxt = (pos == 2'd3) ? 2'd1 : pos + 2'd1;
        end else begin
            nxt = pos;
        end
        return nxt;
    endfunction

    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} - 4'd1) * 4'd3 + ({2'b00, col} - 4'd1);
    endfunction

endpackage

// File: rtl/tt_btn_debounce.sv
// Push-button front end: 2-flop synchronizer, consecutive-sample counter
// filter, and a one-cycle pulse on each accepted rising level.
module tt_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, then flip the level only after a full run of differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            sync1_r   <= btn;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign pulse = level_r & ~level_d_r;

endmodule

// File: rtl/tt_move_ctrl.sv
// Player-input controller: debounced buttons drive a wrapping 3x3 cursor and a
// place/settle/over/clear sequence toward the board.
module tt_move_ctrl
    import tt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_place,
    input  logic               btn_new,
    input  logic [BOARD_N-1:0] board_valid,
    input  logic [1:0]         game_state,
    output logic [1:0]         row,
    output logic [1:0]         col,
    output logic               set,
    output logic               board_reset,
    output logic [BOARD_N-1:0] cursor_onehot,
    output logic               next_symbol,
    output logic [3:0]         move_count,
    output logic               reject,
    output logic               game_over
);

    logic [5:0] raw_s;
    logic [5:0] evt_s;

    assign raw_s = {btn_new, btn_place, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 6; i++) begin : g_btn
        tt_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .btn    (raw_s[i]),
            .pulse  (evt_s[i])
        );
    end

    move_state_e state_r, state_next_s;
    logic [1:0]  row_r, row_next_s;
    logic [1:0]  col_r, col_next_s;
    logic [3:0]  mc_r, mc_next_s;
    logic        settle_r, settle_next_s;
    logic        set_r, board_reset_r, reject_r, game_over_r;
    logic        reject_s;
    logic        move_ok_s;
    logic [3:0]  cell_idx_s;

    assign cell_idx_s = cell_index(row_r, col_r);

    // Next-state, cursor and move-count decisions; new beats place beats moves.
    always_comb begin
        state_next_s  = state_r;
        row_next_s    = row_r;
        col_next_s    = col_r;
        mc_next_s     = mc_r;
        settle_next_s = settle_r;
        reject_s      = 1'b0;
        move_ok_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (evt_s[5]) begin
                    state_next_s = ST_CLEAR;
                end else if (evt_s[4]) begin
                    if (board_valid[cell_idx_s]) begin
                        reject_s = 1'b1;
                    end else begin
                        state_next_s = ST_PLACE;
                    end
                end else begin
                    move_ok_s = 1'b1;
                end
            end
            ST_PLACE: begin
                mc_next_s     = (mc_r == 4'd9) ? 4'd9 : mc_r + 4'd1;
                settle_next_s = 1'b0;
                state_next_s  = evt_s[5] ? ST_CLEAR : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (evt_s[5]) begin
                    state_next_s = ST_CLEAR;
                end else if (settle_r) begin
                    state_next_s = (game_state != GS_PLAY) ? ST_OVER : ST_IDLE;
                end else begin
                    settle_next_s = 1'b1;
                end
            end
            ST_OVER: begin
                if (evt_s[5]) begin
                    state_next_s = ST_CLEAR;
                end else if (evt_s[4]) begin
                    reject_s = 1'b1;
                end else begin
                    move_ok_s = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_CLEAR;
            end
        endcase

        if (move_ok_s) begin
            row_next_s = cursor_step(row_r, evt_s[0], evt_s[1]);
            col_next_s = cursor_step(col_r, evt_s[2], evt_s[3]);
        end else begin
            row_next_s = row_r;
            col_next_s = col_r;
        end

        if (state_next_s == ST_CLEAR) begin
            mc_next_s = 4'd0;
        end else begin
            mc_next_s = mc_next_s;
        end
    end

    // State and registered outputs; reset lands in CLEAR so the board is wiped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_CLEAR;
            row_r         <= CURSOR_ROW_RST;
            col_r         <= CURSOR_COL_RST;
            mc_r          <= 4'd0;
            settle_r      <= 1'b0;
            set_r         <= 1'b0;
            board_reset_r <= 1'b1;
            reject_r      <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            row_r         <= row_next_s;
            col_r         <= col_next_s;
            mc_r          <= mc_next_s;
            settle_r      <= settle_next_s;
            set_r         <= (state_next_s == ST_PLACE);
            board_reset_r <= (state_next_s == ST_CLEAR);
            reject_r      <= reject_s;
            game_over_r   <= (state_next_s == ST_OVER);
        end
    end

    assign row           = row_r;
    assign col           = col_r;
    assign set           = set_r;
    assign board_reset   = board_reset_r;
    assign reject        = reject_r;
    assign game_over     = game_over_r;
    assign move_count    = mc_r;
    assign next_symbol   = ~mc_r[0];
    assign cursor_onehot = {{(BOARD_N-1){1'b0}}, 1'b1} << cell_idx_s;

endmodule

// File: tb/tb_tt_move_ctrl.sv
// Directed bench for tt_move_ctrl with a small behavioural board model.
module tb_tt_move_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] btn = 6'b000000;   // {new, place, right, left, down, up}
    logic [8:0] board_valid;
    logic [1:0] game_state;
    logic [1:0] row, col;
    logic       set, board_reset, next_symbol, reject, game_over;
    logic [8:0] cursor_onehot;
    logic [3:0] move_count;

    int checks = 0;
    int errors = 0;
    int set_cnt = 0, rej_cnt = 0, brst_cnt = 0, overlap_cnt = 0;

    always #5 clk = ~clk;

    tt_move_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
        .btn_place(btn[4]), .btn_new(btn[5]),
        .board_valid(board_valid), .game_state(game_state),
        .row(row), .col(col), .set(set), .board_reset(board_reset),
        .cursor_onehot(cursor_onehot), .next_symbol(next_symbol),
        .move_count(move_count), .reject(reject), .game_over(game_over)
    );

    function automatic int bidx(input logic [1:0] r, input logic [1:0] c);
        return (int'(r) - 1) * 3 + (int'(c) - 1);
    endfunction

    // Board model: cell fills on set, result registers one cycle after the cells.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            board_valid <= 9'b000000000;
            game_state  <= 2'b00;
        end else if (board_reset) begin
            board_valid <= 9'b000000000;
            game_state  <= 2'b00;
        end else begin
            if (set) board_valid[bidx(row, col)] <= 1'b1;
            game_state <= ($countones(board_valid) >= 5) ? 2'b01 : 2'b00;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            set_cnt  <= set_cnt + int'(set);
            rej_cnt  <= rej_cnt + int'(reject);
            brst_cnt <= brst_cnt + int'(board_reset);
            overlap_cnt <= overlap_cnt + int'((set & board_reset) | (set & reject));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [5:0] mask);
        btn = mask;
        tick(8);
        btn = 6'b000000;
        tick(8);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        btn = 6'b000000;
        tick(2);
        checks++; if (board_reset !== 1'b1) begin errors++; $display("FAIL rst_board_reset got %0b want 1", board_reset); end
        checks++; if (row !== 2'd2 || col !== 2'd2) begin errors++; $display("FAIL rst_cursor got %0d,%0d want 2,2", row, col); end
        checks++; if (cursor_onehot !== 9'b000010000) begin errors++; $display("FAIL rst_onehot got %b want 000010000", cursor_onehot); end
        checks++; if (move_count !== 4'd0 || set !== 1'b0 || reject !== 1'b0) begin errors++; $display("FAIL rst_counts got mc=%0d set=%0b rej=%0b want 0 0 0", move_count, set, reject); end
        reset_n = 1'b1;
        #1;
        checks++; if (board_reset !== 1'b1) begin errors++; $display("FAIL rel_board_reset_hold got %0b want 1", board_reset); end
        tick(1);
        checks++; if (board_reset !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL rel_board_reset_drop got brst=%0b go=%0b want 0 0", board_reset, game_over); end
    endtask

    task automatic test_debounce;
        int s0;
        int n;
        s0 = set_cnt;
        btn[4] = 1'b1;
        tick(DB - 1);
        btn = 6'b000000;
        tick(12);
        checks++; if (set_cnt !== s0 || move_count !== 4'd0) begin errors++; $display("FAIL short_pulse got sets=%0d mc=%0d want %0d 0", set_cnt - s0, move_count, 0); end
        btn[4] = 1'b1;
        n = 0;
        while (set !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checks++; if (n !== DB + 3) begin errors++; $display("FAIL set_latency got %0d want %0d", n, DB + 3); end
        checks++; if (row !== 2'd2 || col !== 2'd2) begin errors++; $display("FAIL set_cursor got %0d,%0d want 2,2", row, col); end
        btn = 6'b000000;
        tick(12);
        checks++; if (set_cnt !== s0 + 1) begin errors++; $display("FAIL set_once got %0d want %0d", set_cnt - s0, 1); end
        checks++; if (move_count !== 4'd1 || next_symbol !== 1'b0) begin errors++; $display("FAIL after_place got mc=%0d ns=%0b want 1 0", move_count, next_symbol); end
    endtask

    task automatic test_wrap;
        press(6'b000001);
        press(6'b000001);
        checks++; if (row !== 2'd3) begin errors++; $display("FAIL up_wrap got %0d want 3", row); end
        press(6'b000100);
        press(6'b000100);
        checks++; if (col !== 2'd3) begin errors++; $display("FAIL left_wrap got %0d want 3", col); end
        press(6'b000011);
        checks++; if (row !== 2'd3) begin errors++; $display("FAIL up_down_cancel got %0d want 3", row); end
        press(6'b000010);
        checks++; if (row !== 2'd1 || cursor_onehot !== 9'b000000100) begin errors++; $display("FAIL down_wrap got row=%0d oh=%b want 1 000000100", row, cursor_onehot); end
        press(6'b000010);
        press(6'b001000);
        press(6'b001000);
        checks++; if (row !== 2'd2 || col !== 2'd2) begin errors++; $display("FAIL cursor_home got %0d,%0d want 2,2", row, col); end
    endtask

    task automatic test_occupied;
        int r0;
        int s0;
        r0 = rej_cnt;
        s0 = set_cnt;
        press(6'b010000);
        checks++; if (rej_cnt !== r0 + 1) begin errors++; $display("FAIL occ_reject got %0d want 1", rej_cnt - r0); end
        checks++; if (set_cnt !== s0 || move_count !== 4'd1) begin errors++; $display("FAIL occ_noset got sets=%0d mc=%0d want 0 1", set_cnt - s0, move_count); end
    endtask

    task automatic test_game_over;
        int r0;
        int s0;
        s0 = set_cnt;
        press(6'b001000); press(6'b010000);
        press(6'b000100); press(6'b000100); press(6'b010000);
        press(6'b000001); press(6'b010000);
        press(6'b001000); press(6'b010000);
        checks++; if (set_cnt !== s0 + 4) begin errors++; $display("FAIL go_sets got %0d want 4", set_cnt - s0); end
        checks++; if (game_over !== 1'b1 || move_count !== 4'd5 || next_symbol !== 1'b0) begin errors++; $display("FAIL go_state got go=%0b mc=%0d ns=%0b want 1 5 0", game_over, move_count, next_symbol); end
        r0 = rej_cnt;
        s0 = set_cnt;
        press(6'b010000);
        checks++; if (rej_cnt !== r0 + 1 || set_cnt !== s0) begin errors++; $display("FAIL go_reject got rej=%0d sets=%0d want 1 0", rej_cnt - r0, set_cnt - s0); end
        press(6'b000010);
        checks++; if (row !== 2'd2 || col !== 2'd2 || game_over !== 1'b1) begin errors++; $display("FAIL go_move got %0d,%0d go=%0b want 2,2 1", row, col, game_over); end
        r0 = brst_cnt;
        press(6'b100000);
        checks++; if (brst_cnt !== r0 + 1 || game_over !== 1'b0 || move_count !== 4'd0) begin errors++; $display("FAIL go_new got brst=%0d go=%0b mc=%0d want 1 0 0", brst_cnt - r0, game_over, move_count); end
    endtask

    task automatic test_new_mid_settle;
        int s0;
        int b0;
        s0 = set_cnt;
        b0 = brst_cnt;
        btn[4] = 1'b1;
        tick(2);
        btn[5] = 1'b1;
        tick(7);
        checks++; if (board_reset !== 1'b1 || move_count !== 4'd0) begin errors++; $display("FAIL mid_clear got brst=%0b mc=%0d want 1 0", board_reset, move_count); end
        checks++; if (set_cnt !== s0 + 1) begin errors++; $display("FAIL mid_set_stands got %0d want 1", set_cnt - s0); end
        tick(1);
        checks++; if (board_reset !== 1'b0 || game_over !== 1'b0 || brst_cnt !== b0 + 1) begin errors++; $display("FAIL mid_idle got brst=%0b go=%0b pulses=%0d want 0 0 1", board_reset, game_over, brst_cnt - b0); end
        btn = 6'b000000;
        tick(12);
        checks++; if (move_count !== 4'd0 || set_cnt !== s0 + 1) begin errors++; $display("FAIL mid_after got mc=%0d sets=%0d want 0 1", move_count, set_cnt - s0); end
    endtask

    task automatic test_reset_mid;
        press(6'b001000);
        btn[4] = 1'b1;
        tick(DB + 3);
        checks++; if (set !== 1'b1) begin errors++; $display("FAIL pre_abort_set got %0b want 1", set); end
        reset_n = 1'b0;
        #1;
        checks++; if (set !== 1'b0 || board_reset !== 1'b1 || col !== 2'd2 || move_count !== 4'd0) begin errors++; $display("FAIL abort got set=%0b brst=%0b col=%0d mc=%0d want 0 1 2 0", set, board_reset, col, move_count); end
        tick(2);
        btn = 6'b000000;
        reset_n = 1'b1;
        tick(12);
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL overlap got %0d want 0", overlap_cnt); end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_wrap;
        test_occupied;
        test_game_over;
        test_new_mid_settle;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
